// File: rtl/hack_soc_pkg.sv
// Shared Hack SoC types: word/address widths used by the CPU, ROM and boot loader,
// plus the boot loader state encoding.
package hack_soc_pkg;

    localparam int HACK_WORD_W = 16;
    localparam int HACK_ADDR_W = 15;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CSUM,
        DONE,
        ERROR
    } loader_state_e;

endpackage

// File: rtl/hack_byte_packer.sv
// Pairs a latched high byte with the incoming low byte and presents a registered
// one-cycle word write (strobe, address, data); address and data hold between writes.
module hack_byte_packer
    import hack_soc_pkg::*;
#(
    parameter int ADDR_W = HACK_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   hi_en,
    input  logic                   lo_en,
    input  logic [7:0]             byte_in,
    input  logic [ADDR_W-1:0]      addr_in,
    output logic                   word_we,
    output logic [ADDR_W-1:0]      word_addr,
    output logic [HACK_WORD_W-1:0] word_data
);

    logic [7:0]             hi_q,   hi_d;
    logic                   we_q,   we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [HACK_WORD_W-1:0] data_q, data_d;

    always_comb begin
        hi_d   = hi_en ? byte_in : hi_q;
        we_d   = lo_en;
        addr_d = lo_en ? addr_in : addr_q;
        data_d = lo_en ? {hi_q, byte_in} : data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            hi_q   <= hi_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign word_we   = we_q;
    assign word_addr = addr_q;
    assign word_data = data_q;

endmodule

// File: rtl/hack_rom_loader.sv
// Boot loader: length-prefixed big-endian byte stream -> instruction ROM writes,
// holding the Hack CPU in reset until the image is in. Optional trailing checksum
// byte is enabled by defining HACK_LOADER_CHECKSUM_EN.
//
// state   | meaning
// LEN_HI  | waiting for word count high byte
// LEN_LO  | waiting for word count low byte; range-check N
// DATA_HI | waiting for high byte of next word
// DATA_LO | waiting for low byte; triggers ROM write
// CSUM    | waiting for checksum byte (checksum build only)
// DONE    | image loaded, CPU released; reload restarts
// ERROR   | load aborted, CPU held; reload restarts
module hack_rom_loader
    import hack_soc_pkg::*;
#(
    parameter int ADDR_W    = HACK_ADDR_W,
    parameter int ROM_DEPTH = 32768
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   reload,
    output logic                   rom_we,
    output logic [ADDR_W-1:0]      rom_addr,
    output logic [HACK_WORD_W-1:0] rom_wdata,
    output logic                   cpu_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

`ifdef HACK_LOADER_CHECKSUM_EN
    localparam loader_state_e AFTER_LAST = CSUM;
`else
    localparam loader_state_e AFTER_LAST = DONE;
`endif
    localparam logic [ADDR_W:0] CNT_ONE = 1;

    loader_state_e   state_q, state_d;
    logic [ADDR_W:0] cnt_q,   cnt_d;
    logic [15:0]     len_q,   len_d;
    logic            accept, hi_en, lo_en, released;
    logic [15:0]     n_full;
`ifdef HACK_LOADER_CHECKSUM_EN
    logic [7:0]      sum_q, sum_d;
    logic [7:0]      csum_chk;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LEN_HI;
            cnt_q   <= '0;
            len_q   <= '0;
`ifdef HACK_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
`ifdef HACK_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        hi_en   = 1'b0;
        lo_en   = 1'b0;
        accept  = s_valid && s_ready;
        n_full  = {len_q[15:8], s_data};
`ifdef HACK_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
        csum_chk = s_data + sum_q;
`endif
        case (state_q)
            LEN_HI: begin
`ifdef HACK_LOADER_CHECKSUM_EN
                sum_d = '0;
`endif
                if (accept) begin
                    len_d[15:8] = s_data;
                    cnt_d       = '0;
                    state_d     = LEN_LO;
                end
            end
            LEN_LO: if (accept) begin
                len_d[7:0] = s_data;
                if (n_full == 16'h0000)
                    state_d = AFTER_LAST;
                else if ({16'h0000, n_full} > 32'(ROM_DEPTH))
                    state_d = ERROR;
                else
                    state_d = DATA_HI;
            end
            DATA_HI: if (accept) begin
                hi_en   = 1'b1;
                state_d = DATA_LO;
`ifdef HACK_LOADER_CHECKSUM_EN
                sum_d   = sum_q + s_data;
`endif
            end
            DATA_LO: if (accept) begin
                lo_en   = 1'b1;
                cnt_d   = cnt_q + CNT_ONE;
                state_d = (32'(cnt_q) + 32'd1 == 32'(len_q)) ? AFTER_LAST : DATA_HI;
`ifdef HACK_LOADER_CHECKSUM_EN
                sum_d   = sum_q + s_data;
`endif
            end
`ifdef HACK_LOADER_CHECKSUM_EN
            CSUM: if (accept) begin
                state_d = (csum_chk == 8'h00) ? DONE : ERROR;
            end
`endif
            DONE, ERROR: if (reload) begin
                state_d = LEN_HI;
                cnt_d   = '0;
            end
            default: state_d = LEN_HI;
        endcase
    end

    // The final write is still in flight on the first DONE cycle; keep the CPU held until it lands.
    always_comb begin
        released  = (state_q == DONE) && !rom_we;
        s_ready   = (state_q != DONE) && (state_q != ERROR);
        cpu_reset = !released;
        done      = released;
        err       = (state_q == ERROR);
        busy      = !released && (state_q != ERROR);
    end

    hack_byte_packer #(.ADDR_W(ADDR_W)) u_packer (
        .clk       (clk),
        .reset     (reset),
        .hi_en     (hi_en),
        .lo_en     (lo_en),
        .byte_in   (s_data),
        .addr_in   (cnt_q[ADDR_W-1:0]),
        .word_we   (rom_we),
        .word_addr (rom_addr),
        .word_data (rom_wdata)
    );

endmodule

// File: tb/tb_hack_rom_loader.sv
// Self-checking bench for hack_rom_loader: randomized streams and gaps checked against
// a stream-level model of the expected ROM writes and final outcome.
module tb_hack_rom_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        reload = 1'b0;
    logic        rom_we;
    logic [14:0] rom_addr;
    logic [15:0] rom_wdata;
    logic        cpu_reset, busy, done, err;

    int checks = 0;
    int errors = 0;

    logic [30:0] wq[$];
    logic [30:0] eq[$];
    logic [7:0]  sq[$];
    logic [15:0] wl[$];
    bit          exp_err;
    int          cyc = 0, last_we_cyc = -1, fall_cyc = -1, overlap = 0;
    logic        prev_cr = 1'b1;

    always #5 clk = ~clk;

    hack_rom_loader dut (
        .clk       (clk),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .reload    (reload),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always @(negedge clk) begin
        cyc++;
        if (rom_we) begin
            wq.push_back({rom_addr, rom_wdata});
            last_we_cyc = cyc;
            if (!cpu_reset) overlap++;
        end
        if (prev_cr && !cpu_reset) fall_cyc = cyc;
        prev_cr = cpu_reset;
    end

    // Stream image from the word list: count, words, and the checksum byte in that build.
    function automatic void build();
        int sum;
        sum = 0;
        sq.delete();
        sq.push_back(8'(wl.size() >> 8));
        sq.push_back(8'(wl.size()));
        foreach (wl[i]) begin
            sq.push_back(wl[i][15:8]);
            sq.push_back(wl[i][7:0]);
            sum += int'(wl[i][15:8]) + int'(wl[i][7:0]);
        end
`ifdef HACK_LOADER_CHECKSUM_EN
        sq.push_back(8'((256 - (sum % 256)) % 256));
`endif
    endfunction

    function automatic void model();
        int n, sum;
        eq.delete();
        exp_err = 1'b0;
        n = int'({sq[0], sq[1]});
        if (n > 32768) begin
            exp_err = 1'b1;
            return;
        end
        sum = 0;
        for (int i = 0; i < n; i++) begin
            eq.push_back({15'(i), sq[2+2*i], sq[3+2*i]});
            sum += int'(sq[2+2*i]) + int'(sq[3+2*i]);
        end
`ifdef HACK_LOADER_CHECKSUM_EN
        exp_err = ((sum + int'(sq[2+2*n])) % 256) != 0;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; s_valid = 1'b0; reload = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic send(input int nbytes, input int max_gap);
        for (int i = 0; i < nbytes; i++) begin
            int g, t;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (g) begin
                @(negedge clk);
                s_valid = 1'b0;
                s_data  = 8'($urandom);
            end
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = sq[i];
            t = 0;
            while (!s_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (!s_ready) begin
                errors++;
                $display("FAIL ready_timeout byte %0d got s_ready=0 want 1", i);
            end
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({rom_we, rom_addr, rom_wdata} !== 32'h0) begin
            errors++;
            $display("FAIL reset_rom got %h want 0", {rom_we, rom_addr, rom_wdata});
        end
        checks++;
        if ({cpu_reset, busy, done, err, s_ready} !== 5'b11001) begin
            errors++;
            $display("FAIL reset_ctl got %b want 11001", {cpu_reset, busy, done, err, s_ready});
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        wl = '{16'h1234, 16'hABCD, 16'h7FFF};
        build(); model();
        wq.delete(); fall_cyc = -1; overlap = 0;
        send(sq.size(), 0);
        checks++;
        if (wq.size() != 3) begin
            errors++;
            $display("FAIL basic_count got %0d want 3", wq.size());
        end
        foreach (eq[i]) begin
            checks++;
            if (i >= wq.size() || wq[i] !== eq[i]) begin
                errors++;
                $display("FAIL basic_write%0d got %h want %h", i, (i < wq.size()) ? wq[i] : 31'h0, eq[i]);
            end
        end
        checks++;
        if (fall_cyc != last_we_cyc + 1 || overlap != 0) begin
            errors++;
            $display("FAIL basic_release got fall=%0d lastwe=%0d overlap=%0d want fall=lastwe+1 overlap=0",
                     fall_cyc, last_we_cyc, overlap);
        end
        checks++;
        if ({done, cpu_reset, busy, err, s_ready} !== 5'b10000) begin
            errors++;
            $display("FAIL basic_done got %b want 10000", {done, cpu_reset, busy, err, s_ready});
        end
    endtask

    task automatic test_zero_len();
        pulse_reload();
        wl.delete();
        build(); model();
        wq.delete();
        send(sq.size(), 0);
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("FAIL zero_writes got %0d want 0", wq.size());
        end
        checks++;
        if ({done, cpu_reset, err} !== 3'b100) begin
            errors++;
            $display("FAIL zero_done got %b want 100", {done, cpu_reset, err});
        end
    endtask

    task automatic test_overflow();
        pulse_reload();
        sq = '{8'h80, 8'h01};
        wq.delete();
        send(2, 0);
        checks++;
        if ({err, s_ready, cpu_reset, busy, done, wq.size() == 0} !== 6'b101001) begin
            errors++;
            $display("FAIL ovf_err got err/rdy/crst/busy/done/nowr=%b want 101001",
                     {err, s_ready, cpu_reset, busy, done, wq.size() == 0});
        end
        pulse_reload();
        checks++;
        if ({err, s_ready, cpu_reset, busy, done} !== 5'b01110) begin
            errors++;
            $display("FAIL ovf_reload got %b want 01110", {err, s_ready, cpu_reset, busy, done});
        end
    endtask

    task automatic test_max_len();
        sq = '{8'h80, 8'h00};
        send(2, 0);
        checks++;
        if ({err, busy, s_ready, cpu_reset} !== 4'b0111) begin
            errors++;
            $display("FAIL maxlen_accept got %b want 0111", {err, busy, s_ready, cpu_reset});
        end
        do_reset();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            wl.delete();
            repeat ($urandom_range(1, 6)) wl.push_back(16'($urandom));
            build(); model();
            wq.delete();
            send(sq.size(), (k == 0) ? 0 : 20);
            checks++;
            if (wq.size() != eq.size()) begin
                errors++;
                $display("FAIL rand%0d_count got %0d want %0d", k, wq.size(), eq.size());
            end
            foreach (eq[i]) begin
                checks++;
                if (i >= wq.size() || wq[i] !== eq[i]) begin
                    errors++;
                    $display("FAIL rand%0d_write%0d got %h want %h", k, i, (i < wq.size()) ? wq[i] : 31'h0, eq[i]);
                end
            end
            checks++;
            if ({done, err} !== {!exp_err, exp_err}) begin
                errors++;
                $display("FAIL rand%0d_end got done/err=%b want %b", k, {done, err}, {!exp_err, exp_err});
            end
            pulse_reload();
        end
    endtask

    task automatic test_mid_reset();
        wl = '{16'h1122, 16'h3344, 16'h5566, 16'h7788};
        build();
        send(5, 0);
        do_reset();
        checks++;
        if ({rom_addr, rom_wdata, busy, cpu_reset} !== 33'h3) begin
            errors++;
            $display("FAIL midrst_clear got %h want 3", {rom_addr, rom_wdata, busy, cpu_reset});
        end
        wl = '{16'h55AA};
        build(); model();
        wq.delete();
        send(sq.size(), 0);
        checks++;
        if (wq.size() != 1 || wq[0] !== {15'h0, 16'h55AA}) begin
            errors++;
            $display("FAIL midrst_write got n=%0d w=%h want n=1 w=%h", wq.size(),
                     (wq.size() > 0) ? wq[0] : 31'h0, {15'h0, 16'h55AA});
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL midrst_done got %b want 1", done);
        end
    endtask

`ifdef HACK_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        pulse_reload();
        sq = '{8'h00, 8'h01, 8'h01, 8'h02, 8'hFD};
        send(5, 0);
        checks++;
        if ({done, err} !== 2'b10) begin
            errors++;
            $display("FAIL csum_good got %b want 10", {done, err});
        end
        pulse_reload();
        sq = '{8'h00, 8'h01, 8'h01, 8'h02, 8'hFC};
        send(5, 0);
        checks++;
        if ({done, err, cpu_reset} !== 3'b011) begin
            errors++;
            $display("FAIL csum_bad got %b want 011", {done, err, cpu_reset});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_overflow();
        test_max_len();
        test_back_to_back();
        test_mid_reset();
`ifdef HACK_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
